// File: rtl/imgfetch_pkg.sv
// Shared types for the image line fetcher: FSM state encoding and FIFO tag layout.
package imgfetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROOM  = 3'd1,
        ST_BURST = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Bit position of the end-of-line tag above a dw-bit data word.
    function automatic int tag_last(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/imgfetch_sfifo.sv
// Synchronous first-word fall-through FIFO with fill count and synchronous flush.
module sfifo #(
    parameter int W      = 33,
    parameter int LGFIFO = 10
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_wr,
    input  logic [W-1:0]    i_data,
    input  logic            i_rd,
    output logic            o_valid,
    output logic [W-1:0]    o_data,
    output logic [LGFIFO:0] o_fill
);
    localparam int FW    = LGFIFO + 1;
    localparam int DEPTH = 32'd1 << LGFIFO;
    localparam logic [LGFIFO:0] FULL = FW'(DEPTH);

    logic [W-1:0]        mem_q [DEPTH];
    logic [LGFIFO-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LGFIFO-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LGFIFO:0]     fill_q, fill_d;
    logic                do_wr_s, do_rd_s;

    // Pointer and fill update; a read frees a slot so a write when full still lands.
    always_comb begin
        do_rd_s  = i_rd && (fill_q != FW'(0));
        do_wr_s  = i_wr && ((fill_q != FULL) || do_rd_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (i_flush) begin
            wr_ptr_d = LGFIFO'(0);
            rd_ptr_d = LGFIFO'(0);
            fill_d   = FW'(0);
        end else begin
            if (do_wr_s) wr_ptr_d = wr_ptr_q + LGFIFO'(1);
            else         wr_ptr_d = wr_ptr_q;
            if (do_rd_s) rd_ptr_d = rd_ptr_q + LGFIFO'(1);
            else         rd_ptr_d = rd_ptr_q;
            case ({do_wr_s, do_rd_s})
                2'b10:   fill_d = fill_q + FW'(1);
                2'b01:   fill_d = fill_q - FW'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    // Pointer and fill registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= LGFIFO'(0);
            rd_ptr_q <= LGFIFO'(0);
            fill_q   <= FW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array, written only when the write is accepted and not flushed.
    always_ff @(posedge i_clk) begin
        if (do_wr_s && !i_flush) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_valid = (fill_q != FW'(0));
    assign o_data  = mem_q[rd_ptr_q];
    assign o_fill  = fill_q;

endmodule

// File: rtl/imgfetch.sv
// Image line fetcher: walks a rectangle with Wishbone pipelined bursts into a tagged FIFO.
// Optional IMGFETCH_LINEDOUBLE_EN fetches every memory line twice.
module imgfetch
    import imgfetch_pkg::*;
#(
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int LGFIFO  = 10,
    parameter int LGBURST = 4,
    parameter int WW      = 12,
    parameter int LW      = 11
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_newframe,
    input  logic [AW-1:0] i_baseaddr,
    input  logic [WW-1:0] i_linewords,
    input  logic [AW-1:0] i_linestride,
    input  logic [LW-1:0] i_nlines,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic [AW-1:0] o_wb_addr,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data,
    input  logic          i_rd,
    output logic          o_valid,
    output logic [DW-1:0] o_word,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_err
);
    localparam int TAG_LAST = tag_last(DW);
    localparam int BL       = LGBURST + 1;
    localparam int FW       = LGFIFO + 1;
    localparam int MAXB     = 32'd1 << LGBURST;
    localparam logic [LGFIFO:0] FULL = FW'(32'd1 << LGFIFO);

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d, stb_q, stb_d, err_q, err_d;
    logic [AW-1:0] addr_q, addr_d, line_addr_q, line_addr_d, stride_q, stride_d;
    logic [WW-1:0] word_q, word_d, lw_q, lw_d;
    logic [LW-1:0] vpos_q, vpos_d, nl_q, nl_d;
    logic [BL-1:0] blen_q, blen_d, nstb_q, nstb_d, nack_q, nack_d;

    logic [WW-1:0] remain_s, ack_word_s;
    logic [BL-1:0] room_blen_s;
    logic [FW-1:0] fill_s, free_s;
    logic          enough_s, ack_s, bus_err_s, accept_s, fifo_wr_s, last_s;
    logic          burst_end_s, line_end_s, frame_end_s, adv_line_s, empty_geom_s;
    logic [DW:0]   fifo_out_s;

    // Burst sizing, FIFO room, and end-of-burst/line/frame conditions.
    always_comb begin
        remain_s     = lw_q - word_q;
        room_blen_s  = (remain_s > WW'(MAXB)) ? BL'(MAXB) : BL'(remain_s);
        free_s       = FULL - fill_s;
        enough_s     = (free_s >= FW'(room_blen_s));
        ack_s        = cyc_q && i_wb_ack;
        bus_err_s    = (state_q == ST_BURST) && cyc_q && i_wb_err;
        accept_s     = stb_q && !i_wb_stall;
        ack_word_s   = word_q + WW'(nack_q);
        last_s       = (ack_word_s == (lw_q - WW'(1)));
        fifo_wr_s    = ack_s && !i_wb_err && !i_newframe;
        burst_end_s  = ack_s && !i_wb_err && ((nack_q + BL'(1)) == blen_q);
        line_end_s   = burst_end_s && ((word_q + WW'(blen_q)) == lw_q);
        frame_end_s  = line_end_s && ((vpos_q + LW'(1)) == nl_q);
        empty_geom_s = (i_nlines == LW'(0)) || (i_linewords == WW'(0));
`ifdef IMGFETCH_LINEDOUBLE_EN
        adv_line_s   = vpos_q[0];
`else
        adv_line_s   = 1'b1;
`endif
    end

    // Next-state logic; a new frame request overrides every state.
    always_comb begin
        state_d = state_q;
        if (i_newframe) begin
            state_d = empty_geom_s ? ST_DONE : ST_ROOM;
        end else begin
            case (state_q)
                ST_ROOM: begin
                    if (enough_s) state_d = ST_BURST;
                    else          state_d = ST_ROOM;
                end
                ST_BURST: begin
                    if (bus_err_s)        state_d = ST_ERR;
                    else if (burst_end_s) state_d = frame_end_s ? ST_DONE : ST_ROOM;
                    else                  state_d = ST_BURST;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Bus outputs, address/line counters and error latch.
    always_comb begin
        cyc_d = cyc_q;  stb_d = stb_q;  err_d = err_q;  addr_d = addr_q;
        line_addr_d = line_addr_q;  stride_d = stride_q;  word_d = word_q;
        lw_d = lw_q;  vpos_d = vpos_q;  nl_d = nl_q;
        blen_d = blen_q;  nstb_d = nstb_q;  nack_d = nack_q;
        if (i_newframe) begin
            cyc_d = 1'b0;  stb_d = 1'b0;  err_d = 1'b0;
            lw_d = i_linewords;  stride_d = i_linestride;  nl_d = i_nlines;
            line_addr_d = i_baseaddr;  vpos_d = LW'(0);  word_d = WW'(0);
            blen_d = BL'(0);  nstb_d = BL'(0);  nack_d = BL'(0);
        end else begin
            case (state_q)
                ST_ROOM: begin
                    if (enough_s) begin
                        cyc_d  = 1'b1;
                        stb_d  = 1'b1;
                        addr_d = line_addr_q + AW'(word_q);
                        blen_d = room_blen_s;
                        nstb_d = BL'(0);
                        nack_d = BL'(0);
                    end else begin
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                    end
                end
                ST_BURST: begin
                    if (bus_err_s) begin
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                        err_d = 1'b1;
                    end else begin
                        if (accept_s) begin
                            nstb_d = nstb_q + BL'(1);
                            addr_d = addr_q + AW'(1);
                            stb_d  = ((nstb_q + BL'(1)) != blen_q);
                        end else begin
                            nstb_d = nstb_q;
                        end
                        if (ack_s) nack_d = nack_q + BL'(1);
                        else       nack_d = nack_q;
                        if (burst_end_s) begin
                            cyc_d = 1'b0;
                            stb_d = 1'b0;
                            if (line_end_s) begin
                                word_d      = WW'(0);
                                vpos_d      = vpos_q + LW'(1);
                                line_addr_d = adv_line_s ? (line_addr_q + stride_q) : line_addr_q;
                            end else begin
                                word_d = word_q + WW'(blen_q);
                            end
                        end else begin
                            word_d = word_q;
                        end
                    end
                end
                default: begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;  cyc_q <= 1'b0;  stb_q <= 1'b0;  err_q <= 1'b0;
            addr_q <= AW'(0);  line_addr_q <= AW'(0);  stride_q <= AW'(0);
            word_q <= WW'(0);  lw_q <= WW'(0);  vpos_q <= LW'(0);  nl_q <= LW'(0);
            blen_q <= BL'(0);  nstb_q <= BL'(0);  nack_q <= BL'(0);
        end else begin
            state_q <= state_d;  cyc_q <= cyc_d;  stb_q <= stb_d;  err_q <= err_d;
            addr_q <= addr_d;  line_addr_q <= line_addr_d;  stride_q <= stride_d;
            word_q <= word_d;  lw_q <= lw_d;  vpos_q <= vpos_d;  nl_q <= nl_d;
            blen_q <= blen_d;  nstb_q <= nstb_d;  nack_q <= nack_d;
        end
    end

    sfifo #(
        .W      (DW + 1),
        .LGFIFO (LGFIFO)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_newframe),
        .i_wr    (fifo_wr_s),
        .i_data  ({last_s, i_wb_data}),
        .i_rd    (i_rd),
        .o_valid (o_valid),
        .o_data  (fifo_out_s),
        .o_fill  (fill_s)
    );

    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_addr = addr_q;
    assign o_word    = fifo_out_s[DW-1:0];
    assign o_last    = o_valid && fifo_out_s[TAG_LAST];
    assign o_busy    = (state_q == ST_ROOM) || (state_q == ST_BURST);
    assign o_err     = err_q;

endmodule

// File: tb/tb_imgfetch.sv
// Directed and randomised bench for imgfetch with a pipelined Wishbone slave model.
module tb_imgfetch;
    localparam int AW = 24, DW = 32, LGFIFO = 6, LGBURST = 4, WW = 12, LW = 11;
`ifdef IMGFETCH_LINEDOUBLE_EN
    localparam int LD = 1;
`else
    localparam int LD = 0;
`endif

    logic          clk = 1'b0;
    logic          i_reset = 1'b1, i_newframe = 1'b0, i_rd = 1'b0;
    logic [AW-1:0] i_baseaddr = '0, i_linestride = '0;
    logic [WW-1:0] i_linewords = '0;
    logic [LW-1:0] i_nlines = '0;
    logic          o_wb_cyc, o_wb_stb, o_valid, o_last, o_busy, o_err;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_word;
    logic          s_stall = 1'b0, s_ack = 1'b0, s_err = 1'b0, force_ack = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          wb_ack;

    int nchk = 0, npass = 0;
    int lat_min = 2, lat_max = 2, err_at = 0;
    bit stall_rand = 1'b0, rd_rand = 1'b0;

    logic [AW-1:0] str_q[$];
    logic [DW:0]   pop_q[$];
    int            burst_q[$];
    logic [AW-1:0] pq_a[$];
    int            pq_d[$];
    int            cyc_cnt = 0, bcnt = 0, ack_n = 0, due;
    logic          prev_cyc = 1'b0, err_prev = 1'b0, cyc_after_err = 1'b1;

    assign wb_ack = s_ack | force_ack;
    always #5 clk = ~clk;

    imgfetch #(.AW(AW), .DW(DW), .LGFIFO(LGFIFO), .LGBURST(LGBURST), .WW(WW), .LW(LW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_newframe(i_newframe),
        .i_baseaddr(i_baseaddr), .i_linewords(i_linewords),
        .i_linestride(i_linestride), .i_nlines(i_nlines),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr),
        .i_wb_stall(s_stall), .i_wb_ack(wb_ack), .i_wb_err(s_err), .i_wb_data(s_data),
        .i_rd(i_rd), .o_valid(o_valid), .o_word(o_word), .o_last(o_last),
        .o_busy(o_busy), .o_err(o_err)
    );

    // Mid-cycle slave model and monitor: records accepted strobes, pops and burst lengths.
    always @(negedge clk) begin
        if (i_reset || i_newframe) begin
            str_q.delete(); pop_q.delete(); burst_q.delete();
            bcnt = 0; ack_n = 0; cyc_after_err = 1'b1;
        end
        if (o_valid && i_rd && !i_newframe && !i_reset) pop_q.push_back({o_last, o_word});
        if (prev_cyc && !o_wb_cyc) begin burst_q.push_back(bcnt); bcnt = 0; end
        if (err_prev) cyc_after_err = o_wb_cyc;
        prev_cyc = o_wb_cyc;
        if (!o_wb_cyc) begin pq_a.delete(); pq_d.delete(); end
        s_stall = stall_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (o_wb_cyc && o_wb_stb && !s_stall) begin
            due = cyc_cnt + int'($urandom_range(lat_min, lat_max));
            if (pq_d.size() > 0 && due <= pq_d[$]) due = pq_d[$] + 1;
            pq_a.push_back(o_wb_addr); pq_d.push_back(due);
            if (!i_newframe) str_q.push_back(o_wb_addr);
            bcnt++;
        end
        s_ack = 1'b0; s_err = 1'b0; err_prev = 1'b0;
        if (pq_d.size() > 0 && pq_d[0] == cyc_cnt) begin
            s_data = {8'hA5, pq_a[0]};
            void'(pq_a.pop_front()); void'(pq_d.pop_front());
            ack_n++;
            if (err_at != 0 && ack_n == err_at) begin s_err = 1'b1; err_prev = 1'b1; end
            else s_ack = 1'b1;
        end
        cyc_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rd_rand) i_rd = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic frame(input logic [AW-1:0] b, input int lw, input logic [AW-1:0] st, input int nl);
        i_baseaddr = b; i_linewords = WW'(lw); i_linestride = st; i_nlines = LW'(nl);
        i_newframe = 1'b1; step(1); i_newframe = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (o_busy && i < budget) begin step(1); i++; end
        chk("frame_done", 64'(o_busy), 64'd0);
    endtask

    task automatic drain();
        int i = 0;
        rd_rand = 1'b0; i_rd = 1'b1;
        while (o_valid && i < 300) begin step(1); i++; end
        step(1);
        chk("drained", 64'(o_valid), 64'd0);
    endtask

    task automatic wait_strobes(input int n);
        int i = 0;
        while (str_q.size() < n && i < 200) begin step(1); i++; end
        chk("strobes_reached", 64'(str_q.size() >= n), 64'd1);
    endtask

    task automatic check_frame(input logic [AW-1:0] b, input int lw, input logic [AW-1:0] st, input int nl);
        int idx = 0, ln;
        logic [AW-1:0] a;
        chk("word_count", 64'(pop_q.size()), 64'(lw * nl));
        chk("strobe_count", 64'(str_q.size()), 64'(lw * nl));
        for (int v = 0; v < nl; v++) begin
            for (int w = 0; w < lw; w++) begin
                ln = (LD != 0) ? v / 2 : v;
                a = b + st * AW'(ln) + AW'(w);
                if (idx < pop_q.size()) chk("word", 64'(pop_q[idx]), 64'({(w == lw - 1), 8'hA5, a}));
                if (idx < str_q.size()) chk("addr", 64'(str_q[idx]), 64'(a));
                idx++;
            end
        end
    endtask

    initial begin
        step(3); i_reset = 1'b0; step(1);
        chk("rst_cyc", 64'(o_wb_cyc), 64'd0);   chk("rst_stb", 64'(o_wb_stb), 64'd0);
        chk("rst_addr", 64'(o_wb_addr), 64'd0); chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);    chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);

        // Three lines of 40 words, consumer always reading.
        i_rd = 1'b1;
        frame(24'h001000, 40, 24'd64, 3);
        chk("t1_busy_n1", 64'(o_busy), 64'd1);
        chk("t1_stb_n1", 64'(o_wb_stb), 64'd0);
        step(1);
        chk("t1_stb_n2", 64'(o_wb_stb), 64'd1);
        chk("t1_addr_n2", 64'(o_wb_addr), 64'h1000);
        wait_done(2000); drain();
        check_frame(24'h001000, 40, 24'd64, 3);
        chk("t1_nbursts", 64'(burst_q.size()), 64'd9);
        for (int k = 0; k < 9; k++)
            if (k < burst_q.size()) chk("t1_blen", 64'(burst_q[k]), (k % 3 == 2) ? 64'd8 : 64'd16);
        chk("t1_busy_end", 64'(o_busy), 64'd0);

        // Consumer stalled: fetch must stop with the 64-word FIFO full.
        i_rd = 1'b0;
        frame(24'h002000, 100, 24'd128, 1);
        step(300);
        chk("t2_halt_strobes", 64'(str_q.size()), 64'd64);
        chk("t2_halt_bursts", 64'(burst_q.size()), 64'd4);
        chk("t2_halt_busy", 64'(o_busy), 64'd1);
        chk("t2_halt_cyc", 64'(o_wb_cyc), 64'd0);
        chk("t2_halt_valid", 64'(o_valid), 64'd1);
        chk("t2_halt_pops", 64'(pop_q.size()), 64'd0);
        i_rd = 1'b1;
        wait_done(2000); drain();
        check_frame(24'h002000, 100, 24'd128, 1);
        chk("t2_nbursts", 64'(burst_q.size()), 64'd7);

        // Bus error on the fifth ack.
        err_at = 5;
        frame(24'h003000, 40, 24'd64, 2);
        begin
            int i = 0;
            while (!o_err && i < 100) begin step(1); i++; end
        end
        step(30);
        chk("t3_err", 64'(o_err), 64'd1);
        chk("t3_busy", 64'(o_busy), 64'd0);
        chk("t3_cyc", 64'(o_wb_cyc), 64'd0);
        chk("t3_cyc_after_err", 64'(cyc_after_err), 64'd0);
        chk("t3_strobes", 64'(str_q.size()), 64'd7);
        chk("t3_pops", 64'(pop_q.size()), 64'd4);
        err_at = 0;
        frame(24'h003000, 4, 24'd64, 1);
        chk("t3_err_clear", 64'(o_err), 64'd0);
        wait_done(500); drain();
        check_frame(24'h003000, 4, 24'd64, 1);

        // New frame mid-burst with acks in flight, plus forced stale acks.
        i_rd = 1'b0;
        frame(24'h004000, 40, 24'd64, 1);
        wait_strobes(8);
        chk("t4_pre_valid", 64'(o_valid), 64'd1);
        force_ack = 1'b1;
        frame(24'h005000, 3, 24'd64, 1);
        chk("t4_flush_valid", 64'(o_valid), 64'd0);
        chk("t4_flush_cyc", 64'(o_wb_cyc), 64'd0);
        step(1); force_ack = 1'b0;
        chk("t4_stale_valid", 64'(o_valid), 64'd0);
        chk("t4_new_stb", 64'(o_wb_stb), 64'd1);
        chk("t4_new_addr", 64'(o_wb_addr), 64'h5000);
        wait_done(500); drain();
        check_frame(24'h005000, 3, 24'd64, 1);

        // Empty geometry goes straight to DONE.
        frame(24'h007000, 10, 24'd64, 0);
        chk("t5_nl0_busy", 64'(o_busy), 64'd0);
        step(20);
        chk("t5_nl0_strobes", 64'(str_q.size()), 64'd0);
        frame(24'h007000, 0, 24'd64, 2);
        chk("t5_lw0_busy", 64'(o_busy), 64'd0);
        step(20);
        chk("t5_lw0_strobes", 64'(str_q.size()), 64'd0);

`ifdef IMGFETCH_LINEDOUBLE_EN
        frame(24'h006000, 2, 24'd64, 4);
        wait_done(500); drain();
        check_frame(24'h006000, 2, 24'd64, 4);
        chk("ld_addr2", (str_q.size() > 2) ? 64'(str_q[2]) : 64'd0, 64'h6000);
        chk("ld_addr4", (str_q.size() > 4) ? 64'(str_q[4]) : 64'd0, 64'h6040);
`endif

        // Reset mid-burst.
        frame(24'h008000, 40, 24'd64, 1);
        wait_strobes(5);
        i_reset = 1'b1; step(1);
        chk("t6_rst_cyc", 64'(o_wb_cyc), 64'd0);  chk("t6_rst_stb", 64'(o_wb_stb), 64'd0);
        chk("t6_rst_valid", 64'(o_valid), 64'd0); chk("t6_rst_busy", 64'(o_busy), 64'd0);
        chk("t6_rst_addr", 64'(o_wb_addr), 64'd0);
        i_reset = 1'b0; step(2);
        chk("t6_idle_busy", 64'(o_busy), 64'd0);

        // Random stall, ack delay and consumer over many small frames.
        stall_rand = 1'b1; lat_min = 1; lat_max = 4;
        for (int f = 0; f < 100; f++) begin
            logic [AW-1:0] b, st;
            int lw, nl;
            b = AW'($urandom); st = AW'($urandom_range(0, 255));
            lw = int'($urandom_range(1, 40)); nl = int'($urandom_range(1, 3));
            rd_rand = 1'b1;
            frame(b, lw, st, nl);
            wait_done(5000); drain();
            check_frame(b, lw, st, nl);
        end
        stall_rand = 1'b0;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
